// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Byte-serial memory controller arbitrating a fetch port and a data
//            port onto a byte-wide RAM with one-cycle read latency.
//            Optional macro MEMCTRL_IO_GUARD_EN holds off IO-region writes
//            while the UART buffer is full.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    // instruction-fetch port
    input  logic        if_r_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_r_data_o,
    // data port
    input  logic        mem_r_req_i,
    input  logic        mem_w_req_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_w_data_i,
    input  logic [1:0]  mem_state_i,
    output logic        mem_done_o,
    output logic [31:0] mem_r_data_o,
    // RAM side
    input  logic [7:0]  ram_din_i,
    output logic [7:0]  ram_dout_o,
    output logic [31:0] ram_a_o,
    output logic        ram_wr_o,
    input  logic        io_buffer_full_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_FETCH_LAST = 2'b11;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_write;
    logic        r_owner_mem;
    logic [1:0]  r_last;
    logic [2:0]  r_cnt;
    logic [31:0] r_rbuf;

    logic        w_mem_req;
    logic        w_mem_ok;
    logic        w_io_block;
    logic [2:0]  w_cnt_inc;
    logic [2:0]  w_end_cnt;
    logic        w_xfer_end;
    logic [31:0] w_next_a;
    logic [7:0]  w_next_wbyte;
    logic [31:0] w_rbuf_merged;

`ifdef MEMCTRL_IO_GUARD_EN
    assign w_io_block = mem_w_req_i & (mem_addr_i[17:16] == 2'b11) & io_buffer_full_i;
`else
    logic w_unused_io;
    assign w_unused_io = io_buffer_full_i;
    assign w_io_block  = 1'b0;
`endif

    assign w_mem_req  = mem_r_req_i | mem_w_req_i;
    assign w_mem_ok   = w_mem_req & ~w_io_block;
    assign w_cnt_inc  = r_cnt + 3'd1;
    // Reads spend one extra XFER cycle collecting the last byte.
    assign w_end_cnt  = {1'b0, r_last} + {2'b00, ~r_write};
    assign w_xfer_end = (r_cnt == w_end_cnt);
    assign w_next_a   = r_addr + {29'd0, w_cnt_inc};

    always_comb begin
        case (w_cnt_inc[1:0])
            2'd1:    w_next_wbyte = r_wdata[15:8];
            2'd2:    w_next_wbyte = r_wdata[23:16];
            2'd3:    w_next_wbyte = r_wdata[31:24];
            default: w_next_wbyte = r_wdata[7:0];
        endcase
    end

    // The byte on ram_din_i belongs to the address presented one cycle earlier.
    always_comb begin
        w_rbuf_merged = r_rbuf;
        case (r_cnt)
            3'd1:    w_rbuf_merged[7:0]   = ram_din_i;
            3'd2:    w_rbuf_merged[15:8]  = ram_din_i;
            3'd3:    w_rbuf_merged[23:16] = ram_din_i;
            3'd4:    w_rbuf_merged[31:24] = ram_din_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_write      <= 1'b0;
            r_owner_mem  <= 1'b0;
            r_last       <= 2'd0;
            r_cnt        <= 3'd0;
            r_rbuf       <= 32'd0;
            if_done_o    <= 1'b0;
            if_r_data_o  <= 32'd0;
            mem_done_o   <= 1'b0;
            mem_r_data_o <= 32'd0;
            ram_dout_o   <= 8'd0;
            ram_a_o      <= 32'd0;
            ram_wr_o     <= 1'b0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mem_ok) begin
                        r_addr      <= mem_addr_i;
                        r_wdata     <= mem_w_data_i;
                        r_write     <= mem_w_req_i;
                        r_owner_mem <= 1'b1;
                        r_last      <= mem_state_i;
                        r_cnt       <= 3'd0;
                        r_rbuf      <= 32'd0;
                        ram_a_o     <= mem_addr_i;
                        ram_wr_o    <= mem_w_req_i;
                        if (mem_w_req_i) begin
                            ram_dout_o <= mem_w_data_i[7:0];
                        end
                        r_state     <= XFER;
                    end else if (if_r_req_i) begin
                        r_addr      <= if_addr_i;
                        r_write     <= 1'b0;
                        r_owner_mem <= 1'b0;
                        r_last      <= c_FETCH_LAST;
                        r_cnt       <= 3'd0;
                        r_rbuf      <= 32'd0;
                        ram_a_o     <= if_addr_i;
                        ram_wr_o    <= 1'b0;
                        r_state     <= XFER;
                    end
                end
                XFER: begin
                    if (!r_write && (r_cnt != 3'd0)) begin
                        r_rbuf <= w_rbuf_merged;
                    end
                    if (w_xfer_end) begin
                        ram_wr_o <= 1'b0;
                        r_state  <= DONE;
                        if (r_owner_mem) begin
                            mem_done_o <= 1'b1;
                            if (!r_write) begin
                                mem_r_data_o <= w_rbuf_merged;
                            end
                        end else begin
                            if_done_o   <= 1'b1;
                            if_r_data_o <= w_rbuf_merged;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // Past the last byte a read only waits for data; address holds.
                        if (w_cnt_inc <= {1'b0, r_last}) begin
                            ram_a_o <= w_next_a;
                            if (r_write) begin
                                ram_dout_o <= w_next_wbyte;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Self-checking bench for mem_ctrl with a byte-wide RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_r_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_r_data;
    logic        mem_r_req = 1'b0;
    logic        mem_w_req = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_w_data = 32'd0;
    logic [1:0]  mem_state = 2'd0;
    logic        mem_done;
    logic [31:0] mem_r_data;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_full = 1'b0;

`ifdef MEMCTRL_IO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    mem_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .if_r_req_i       (if_r_req),
        .if_addr_i        (if_addr),
        .if_done_o        (if_done),
        .if_r_data_o      (if_r_data),
        .mem_r_req_i      (mem_r_req),
        .mem_w_req_i      (mem_w_req),
        .mem_addr_i       (mem_addr),
        .mem_w_data_i     (mem_w_data),
        .mem_state_i      (mem_state),
        .mem_done_o       (mem_done),
        .mem_r_data_o     (mem_r_data),
        .ram_din_i        (ram_din),
        .ram_dout_o       (ram_dout),
        .ram_a_o          (ram_a),
        .ram_wr_o         (ram_wr),
        .io_buffer_full_i (io_full)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, write-through on ram_wr, plus a preload path.
    logic [7:0]  ram [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_a  = 12'd0;
    logic [7:0]  pl_d  = 8'd0;
    always @(posedge clk) begin
        if (pl_en)       ram[pl_a] <= pl_d;
        else if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
        ram_din <= ram[ram_a[11:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_if  = 32'd0;
    logic [31:0] exp_mem = 32'd0;

    typedef struct {
        logic        fetch;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int n;
        int lat;
        logic seen;
        logic [31:0] sh;
        logic own_done;
        logic oth_done;
        n = v.fetch ? 4 : int'(v.size) + 1;
        @(negedge clk);
        @(negedge clk);
        if (v.fetch) begin
            if_r_req = 1'b1; if_addr = v.addr; mem_state = v.size;
        end else begin
            mem_r_req = v.rd; mem_w_req = v.wr; mem_addr = v.addr;
            mem_w_data = v.wdata; mem_state = v.size;
        end
        @(posedge clk); #1;
        if_r_req = 1'b0; mem_r_req = 1'b0; mem_w_req = 1'b0;
        if_addr = ~v.addr; mem_addr = ~v.addr; mem_w_data = ~v.wdata; mem_state = ~v.size;
        lat = 0;
        seen = 1'b0;
        for (int s = 1; s <= 12 && !seen; s++) begin
            if (s > 1) begin @(posedge clk); #1; end
            if (s <= n) begin
                check($sformatf("v%0d ram_a c%0d", idx, s), ram_a, v.addr + 32'(s - 1));
                if (v.wr) begin
                    sh = v.wdata >> (8 * (s - 1));
                    check($sformatf("v%0d ram_dout c%0d", idx, s), {24'd0, ram_dout}, {24'd0, sh[7:0]});
                end
            end
            check($sformatf("v%0d ram_wr c%0d", idx, s), {31'd0, ram_wr}, {31'd0, v.wr && (s <= n)});
            own_done = v.fetch ? if_done : mem_done;
            oth_done = v.fetch ? mem_done : if_done;
            check($sformatf("v%0d other_done c%0d", idx, s), {31'd0, oth_done}, 32'd0);
            if (own_done) begin
                seen = 1'b1;
                lat = s;
            end
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        if (!v.wr) begin
            if (v.fetch) exp_if = v.exp_data;
            else         exp_mem = v.exp_data;
        end
        check($sformatf("v%0d if_r_data", idx), if_r_data, exp_if);
        check($sformatf("v%0d mem_r_data", idx), mem_r_data, exp_mem);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         2'd3, 6, 32'h4433_2211};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'hDEAD_BEEF, 2'd1, 3, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0101, 32'h0,         2'd0, 3, 32'h0000_0022};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h0,         2'd1, 4, 32'h0000_4433};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         2'd2, 5, 32'h0033_2211};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         2'd3, 6, 32'h4433_2211};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0110, 32'h0000_00A5, 2'd0, 2, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0120, 32'hCAFE_F00D, 2'd3, 5, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0204, 32'h0,         2'd3, 6, 32'h7766_BEEF};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0120, 32'h0,         2'd3, 6, 32'hCAFE_F00D};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h0000_0130, 32'h0000_005C, 2'd0, 2, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0000_0130, 32'h0,         2'd0, 3, 32'h0000_005C};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0,         2'd3, 6, 32'hF0DE_BC9A};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'h0,         2'd0, 6, 32'h7766_BEEF};

        preload(12'h100, 8'h11); preload(12'h101, 8'h22);
        preload(12'h102, 8'h33); preload(12'h103, 8'h44);
        preload(12'h206, 8'h66); preload(12'h207, 8'h77);
        preload(12'hFFE, 8'h9A); preload(12'hFFF, 8'hBC);
        preload(12'h000, 8'hDE); preload(12'h001, 8'hF0);
        preload(12'h010, 8'hAB);
        preload(12'h302, 8'hC2); preload(12'h303, 8'hC3);

        @(posedge clk); #1;
        check("rst if_done", {31'd0, if_done}, 32'd0);
        check("rst mem_done", {31'd0, mem_done}, 32'd0);
        check("rst if_r_data", if_r_data, 32'd0);
        check("rst mem_r_data", mem_r_data, 32'd0);
        check("rst ram_a", ram_a, 32'd0);
        check("rst ram_dout", {24'd0, ram_dout}, 32'd0);
        check("rst ram_wr", {31'd0, ram_wr}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i], i);
        end
        check("sh ram204", {24'd0, ram[12'h204]}, 32'h0000_00EF);
        check("sh ram205", {24'd0, ram[12'h205]}, 32'h0000_00BE);
        check("sh ram206 kept", {24'd0, ram[12'h206]}, 32'h0000_0066);

        // Reset arriving in the second XFER cycle of a word store.
        @(negedge clk); @(negedge clk);
        mem_w_req = 1'b1; mem_addr = 32'h300; mem_w_data = 32'h1122_3344; mem_state = 2'd3;
        @(posedge clk); #1;
        mem_w_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst if_done", {31'd0, if_done}, 32'd0);
        check("midrst mem_done", {31'd0, mem_done}, 32'd0);
        check("midrst if_r_data", if_r_data, 32'd0);
        check("midrst mem_r_data", mem_r_data, 32'd0);
        check("midrst ram_a", ram_a, 32'd0);
        check("midrst ram_dout", {24'd0, ram_dout}, 32'd0);
        check("midrst ram_wr", {31'd0, ram_wr}, 32'd0);
        rst = 1'b0;
        exp_if = 32'd0;
        exp_mem = 32'd0;
        for (int s = 0; s < 6; s++) begin
            @(posedge clk); #1;
            check($sformatf("midrst no done c%0d", s), {31'd0, mem_done | ram_wr}, 32'd0);
        end
        check("midrst ram300", {24'd0, ram[12'h300]}, 32'h0000_0044);
        check("midrst ram301", {24'd0, ram[12'h301]}, 32'h0000_0033);
        check("midrst ram302", {24'd0, ram[12'h302]}, 32'h0000_00C2);
        check("midrst ram303", {24'd0, ram[12'h303]}, 32'h0000_00C3);

        // Arbitration: LB on the data port wins, fetch follows after DONE.
        @(negedge clk); @(negedge clk);
        if_r_req = 1'b1; if_addr = 32'h100;
        mem_r_req = 1'b1; mem_addr = 32'h10; mem_state = 2'd0;
        @(posedge clk); #1;
        mem_r_req = 1'b0; mem_addr = 32'hFFFF_0000;
        for (int s = 1; s <= 12; s++) begin
            if (s > 1) begin @(posedge clk); #1; end
            if (s == 5) if_r_req = 1'b0;
            check($sformatf("arb mem_done c%0d", s), {31'd0, mem_done}, {31'd0, s == 3});
            check($sformatf("arb if_done c%0d", s), {31'd0, if_done}, {31'd0, s == 10});
        end
        check("arb mem_r_data", mem_r_data, 32'h0000_00AB);
        check("arb if_r_data", if_r_data, 32'h4433_2211);

        // IO-region byte store while the UART buffer reports full.
        @(negedge clk); @(negedge clk);
        io_full = 1'b1; mem_w_req = 1'b1; mem_addr = 32'h0003_0000;
        mem_w_data = 32'h0000_0077; mem_state = 2'd0;
        for (int s = 1; s <= 8; s++) begin
            @(posedge clk); #1;
            if (s == (GUARD ? 6 : 1)) mem_w_req = 1'b0;
            if (s == 5) io_full = 1'b0;
            check($sformatf("io ram_wr c%0d", s), {31'd0, ram_wr}, {31'd0, s == (GUARD ? 6 : 1)});
            check($sformatf("io mem_done c%0d", s), {31'd0, mem_done}, {31'd0, s == (GUARD ? 7 : 2)});
        end
        check("io ram30000", {24'd0, ram[12'h000]}, 32'h0000_0077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
